hmac_seq_ctrl: RTL
==================

HMAC_SEQ_CTRL -- requirements
Module: hmac_seq_ctrl

Interface
REQ-001 SHALL have parameter BLK_W, default 64, hash-core block width in bits.
REQ-002 SHALL have parameter KEY_W, default 128, key width; integer multiple of BLK_W.
REQ-003 SHALL have parameter TAG_W, default 256, digest width; integer multiple of BLK_W.
REQ-004 SHALL have parameter MAX_BLOCKS, default 16, message buffer depth in blocks.
REQ-005 SHALL have parameter HASH_TIMEOUT, default 1024, maximum cycles spent waiting for a digest.
REQ-006 SHALL have port clk, in, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, in, 1, asynchronous active-high reset.
REQ-008 SHALL have port start, in, 1, request a new HMAC run.
REQ-009 SHALL have port msg_len, in, $clog2(MAX_BLOCKS+1), message length in blocks, sampled with start.
REQ-010 SHALL have port key, in, KEY_W, HMAC key, sampled with start.
REQ-011 SHALL have ports msg_valid (in, 1), msg_data (in, BLK_W) and msg_ready (out, 1), forming the message load handshake.
REQ-012 SHALL have port hash_init, out, 1, one-cycle pulse that resets the hash core.
REQ-013 SHALL have ports hash_in_valid (out, 1), hash_in_data (out, BLK_W), hash_in_last (out, 1) and hash_in_ready (in, 1), forming the hash input stream.
REQ-014 SHALL have ports hash_out_valid (in, 1) and hash_out_data (in, TAG_W), carrying the digest result.
REQ-015 SHALL have ports tag (out, TAG_W), tag_valid (out, 1), busy (out, 1) and error (out, 1).

Function
REQ-016 SHALL implement states IDLE, LOAD, IKEY, IMSG, IWAIT, OKEY, ODIG, OWAIT, DONE and ERR.
REQ-017 In IDLE, start=1 SHALL register key and msg_len, clear tag_valid and error, and move to LOAD; if msg_len>MAX_BLOCKS it SHALL move to ERR instead.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 LOAD SHALL assert msg_ready, write msg_data into the buffer on each msg_valid&&msg_ready, and move to IKEY once msg_len blocks are written; msg_len=0 SHALL pass through LOAD in one cycle.
REQ-020 Entry to IKEY and entry to OKEY SHALL each produce a hash_init pulse exactly one cycle wide, concurrent with the first cycle of that state.
REQ-021 IKEY SHALL send KEY_W/BLK_W blocks, key XOR 0x36-repeated, most-significant block first; OKEY SHALL do the same with 0x5C-repeated.
REQ-022 IMSG SHALL send buffered blocks 0..msg_len-1 in order; ODIG SHALL send the registered inner digest as TAG_W/BLK_W blocks, MSB first.
REQ-023 A block SHALL transfer only when hash_in_valid&&hash_in_ready; while hash_in_valid=1 and hash_in_ready=0, hash_in_data and hash_in_last SHALL stay stable.
REQ-024 hash_in_last SHALL be 1 on the final block of each pass: the last IMSG block, or the last IKEY block when msg_len=0, and the last ODIG block.
REQ-025 IWAIT SHALL register hash_out_data as the inner digest when hash_out_valid=1 and move to OKEY.
REQ-026 OWAIT SHALL register hash_out_data into tag when hash_out_valid=1 and move to DONE.
REQ-027 A wait counter SHALL clear on entry to IWAIT or OWAIT; if it reaches HASH_TIMEOUT without hash_out_valid, the FSM SHALL move to ERR.
REQ-028 hash_out_valid asserted outside IWAIT and OWAIT SHALL be ignored.
REQ-029 DONE SHALL set tag_valid=1 and move to IDLE in the next cycle; ERR SHALL set error=1 and move to IDLE in the next cycle.
REQ-030 tag, tag_valid and error SHALL hold their values until the next accepted start.
REQ-031 busy SHALL be 1 in every state except IDLE.

Reset
REQ-032 rst=1 SHALL immediately, in any state including mid-transfer, force IDLE and drive msg_ready, hash_init, hash_in_valid, hash_in_last, tag_valid, busy and error to 0, and tag and hash_in_data to 0.
REQ-033 On rst, the buffer contents SHALL be don't-care, but the write pointer, block counter and wait counter SHALL clear to 0.

Verification
REQ-034 With BLK_W=64, KEY_W=128, TAG_W=128, MAX_BLOCKS=4 and hash_in_ready=1: msg_len=2 -> stream {k^ipad hi, k^ipad lo, m0, m1(last)}, then {k^opad hi, k^opad lo, d_hi, d_lo(last)}; tag=second digest; tag_valid=1.
REQ-035 With msg_len=0 -> hash_in_last=1 on the second IKEY block and IMSG is skipped.
REQ-036 With msg_len=5 -> error=1 two cycles after start; hash_init never pulses; busy returns to 0.
REQ-037 With hash_out_valid held at 0 -> error=1 after HASH_TIMEOUT cycles in IWAIT, with no OKEY entry.
REQ-038 With hash_in_ready toggling 1,0,0,1 -> each block is held stable while stalled; the transferred sequence is identical to REQ-034.
REQ-039 With rst pulsed during IMSG -> all outputs return to reset values that cycle, and a following run with msg_len=1 completes correctly.

Source files
------------

// File: rtl/hmac_seq_ctrl.sv
// hmac_seq_ctrl -- sequences an external block hash core through the two
// HMAC passes: H((K^ipad) || msg), then H((K^opad) || inner_digest).
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   start, msg_len, key : run request; msg_len and key are sampled with start
//   msg_valid/msg_data/msg_ready : message block load into the local buffer
//   hash_init           : one-cycle core reset on entry to each pass
//   hash_in_valid/hash_in_data/hash_in_last/hash_in_ready : block stream to core
//   hash_out_valid/hash_out_data : digest returned by the core
//   tag, tag_valid      : final HMAC result, held until the next accepted start
//   busy, error         : run in progress / run aborted (over-length or timeout)
//   o_dbg_state         : current FSM state, for observation only
//
// Handshake rule (msg_* and hash_in_*): a block moves on a rising edge where
// valid && ready are both 1. Once valid is raised it stays raised, and data
// and last stay stable, until that transfer happens.
module hmac_seq_ctrl #(
    parameter int BLK_W        = 64,
    parameter int KEY_W        = 128,
    parameter int TAG_W        = 256,
    parameter int MAX_BLOCKS   = 16,
    parameter int HASH_TIMEOUT = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [$clog2(MAX_BLOCKS+1)-1:0] msg_len,
    input  logic [KEY_W-1:0]                key,
    input  logic                            msg_valid,
    input  logic [BLK_W-1:0]                msg_data,
    output logic                            msg_ready,
    output logic                            hash_init,
    output logic                            hash_in_valid,
    output logic [BLK_W-1:0]                hash_in_data,
    output logic                            hash_in_last,
    input  logic                            hash_in_ready,
    input  logic                            hash_out_valid,
    input  logic [TAG_W-1:0]                hash_out_data,
    output logic [TAG_W-1:0]                tag,
    output logic                            tag_valid,
    output logic                            busy,
    output logic                            error,
    output logic [3:0]                      o_dbg_state
);

    localparam int LW      = $clog2(MAX_BLOCKS + 1);
    localparam int NK      = KEY_W / BLK_W;
    localparam int NT      = TAG_W / BLK_W;
    localparam int CNT_MAX = (MAX_BLOCKS > NK) ? ((MAX_BLOCKS > NT) ? MAX_BLOCKS : NT)
                                               : ((NK > NT) ? NK : NT);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
    localparam int WW      = $clog2(HASH_TIMEOUT + 1);
    localparam logic [KEY_W-1:0] IPAD = {(KEY_W/8){8'h36}};
    localparam logic [KEY_W-1:0] OPAD = {(KEY_W/8){8'h5c}};

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        LOAD  = 4'd1,
        IKEY  = 4'd2,
        IMSG  = 4'd3,
        IWAIT = 4'd4,
        OKEY  = 4'd5,
        ODIG  = 4'd6,
        OWAIT = 4'd7,
        DONE  = 4'd8,
        ERR   = 4'd9
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [KEY_W-1:0]  r_key;
    logic [LW-1:0]     r_len;
    logic [LW-1:0]     r_wptr;
    logic [CW-1:0]     r_blk;
    logic [WW-1:0]     r_wait;
    logic [TAG_W-1:0]  r_inner;
    logic [TAG_W-1:0]  r_tag;
    logic              r_tag_valid;
    logic              r_error;
    logic              r_hash_init;
    logic [BLK_W-1:0]  r_buf [MAX_BLOCKS];

    logic              w_wr;
    logic              w_xfer;
    logic              w_blk_last;
    logic              w_last;
    logic [BLK_W-1:0]  w_data;
    logic [KEY_W-1:0]  w_kx;

    // The init cycle of each pass sends nothing, so the core sees its reset
    // before the first block of that pass.
    assign hash_in_valid = ((r_state == IKEY) || (r_state == IMSG) ||
                            (r_state == OKEY) || (r_state == ODIG)) && !r_hash_init;
    assign w_xfer        = hash_in_valid && hash_in_ready;
    assign msg_ready     = (r_state == LOAD) && (r_len != '0);
    assign w_wr          = msg_valid && msg_ready;
    assign hash_in_data  = hash_in_valid ? w_data : '0;
    assign hash_in_last  = hash_in_valid && w_last;
    assign hash_init     = r_hash_init;
    assign tag           = r_tag;
    assign tag_valid     = r_tag_valid;
    assign error         = r_error;
    assign busy          = (r_state != IDLE);
    assign o_dbg_state   = r_state;

    always_comb begin
        w_next     = r_state;
        w_data     = '0;
        w_last     = 1'b0;
        w_blk_last = 1'b0;
        w_kx       = r_key ^ ((r_state == OKEY) ? OPAD : IPAD);
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (msg_len > LW'(MAX_BLOCKS)) ? ERR : LOAD;
                end
            end
            LOAD: begin
                if (r_len == '0) begin
                    w_next = IKEY;
                end else if (w_wr && (r_wptr == r_len - 1'b1)) begin
                    w_next = IKEY;
                end
            end
            IKEY, OKEY: begin
                // Block 0 is the most-significant slice of the padded key.
                for (int i = 0; i < NK; i++) begin
                    if (r_blk == CW'(NK - 1 - i)) begin
                        w_data = w_kx[i*BLK_W +: BLK_W];
                    end
                end
                w_blk_last = (r_blk == CW'(NK - 1));
                // An empty message ends the inner pass on the key blocks.
                w_last     = (r_state == IKEY) && w_blk_last && (r_len == '0);
                if (w_xfer && w_blk_last) begin
                    if (r_state == OKEY) begin
                        w_next = ODIG;
                    end else begin
                        w_next = (r_len == '0) ? IWAIT : IMSG;
                    end
                end
            end
            IMSG: begin
                w_data     = r_buf[r_blk[IW-1:0]];
                w_blk_last = (r_blk == CW'(r_len) - CW'(1));
                w_last     = w_blk_last;
                if (w_xfer && w_blk_last) begin
                    w_next = IWAIT;
                end
            end
            ODIG: begin
                for (int i = 0; i < NT; i++) begin
                    if (r_blk == CW'(NT - 1 - i)) begin
                        w_data = r_inner[i*BLK_W +: BLK_W];
                    end
                end
                w_blk_last = (r_blk == CW'(NT - 1));
                w_last     = w_blk_last;
                if (w_xfer && w_blk_last) begin
                    w_next = OWAIT;
                end
            end
            IWAIT, OWAIT: begin
                if (hash_out_valid) begin
                    w_next = (r_state == IWAIT) ? OKEY : DONE;
                end else if (r_wait == WW'(HASH_TIMEOUT - 1)) begin
                    // HASH_TIMEOUT cycles have now been spent without a digest.
                    w_next = ERR;
                end
            end
            DONE, ERR: w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_key       <= '0;
            r_len       <= '0;
            r_wptr      <= '0;
            r_blk       <= '0;
            r_wait      <= '0;
            r_inner     <= '0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
            r_error     <= 1'b0;
            r_hash_init <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_hash_init <= ((w_next == IKEY) && (r_state != IKEY)) ||
                           ((w_next == OKEY) && (r_state != OKEY));
            if ((r_state == IDLE) && start) begin
                r_key       <= key;
                r_len       <= msg_len;
                r_wptr      <= '0;
                r_tag_valid <= 1'b0;
                r_error     <= 1'b0;
            end
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            // Block and wait counters restart on every state change.
            if (w_next != r_state) begin
                r_blk <= '0;
            end else if (w_xfer) begin
                r_blk <= r_blk + 1'b1;
            end
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if ((r_state == IWAIT) || (r_state == OWAIT)) begin
                r_wait <= r_wait + 1'b1;
            end
            if ((r_state == IWAIT) && hash_out_valid) begin
                r_inner <= hash_out_data;
            end
            if ((r_state == OWAIT) && hash_out_valid) begin
                r_tag <= hash_out_data;
            end
            if (r_state == DONE) begin
                r_tag_valid <= 1'b1;
            end
            if (r_state == ERR) begin
                r_error <= 1'b1;
            end
        end
    end

    // Message buffer contents need no reset; only the write pointer matters.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_wptr[IW-1:0]] <= msg_data;
        end
    end

endmodule
